// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport master (
        output In_Valid, A, B, Cin, Sub, Out_Ready,
        input  In_Ready, Out_Valid, Sum, Cout, Overflow, Zero
    );

    modport slave (
        input  In_Valid, A, B, Cin, Sub, Out_Ready,
        output In_Ready, Out_Valid, Sum, Cout, Overflow, Zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Two-level carry-lookahead add/subtract with valid/ready flow control,
// one or two register stages.
module pipelined_cla_adder #(
    parameter int WIDTH   = 16,
    parameter int GROUP   = 4,
    parameter int LATENCY = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    // Front end: effective B, per-bit G/P, per-group GG/GP
    logic [WIDTH-1:0] w_beff, w_g, w_p;
    logic [NG-1:0]    w_gg, w_gp;
    logic             w_cin;

    assign w_beff = bus.Sub ? ~bus.B : bus.B;
    assign w_cin  = bus.Sub | bus.Cin;
    assign w_g    = bus.A & w_beff;
    assign w_p    = bus.A ^ w_beff;

    always_comb begin
        logic t_gg, t_gp;
        w_gg = '0;
        w_gp = '0;
        for (int j = 0; j < NG; j++) begin
            t_gg = 1'b0;
            t_gp = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                t_gg = w_g[j*GROUP+k] | (w_p[j*GROUP+k] & t_gg);
                t_gp = t_gp & w_p[j*GROUP+k];
            end
            w_gg[j] = t_gg;
            w_gp[j] = t_gp;
        end
    end

    // Signals feeding the result stage (registered or direct, by LATENCY)
    logic [WIDTH-1:0] w_s_g, w_s_p;
    logic [NG-1:0]    w_s_gg, w_s_gp;
    logic             w_s_cin, w_s_amsb, w_s_bmsb, w_s_vld;

    logic r_ov;
    logic w_ld_out;
    assign w_ld_out = !r_ov | bus.Out_Ready;

    generate
        if (LATENCY == 2) begin : g_two_stage
            logic [WIDTH-1:0] r_g, r_p;
            logic [NG-1:0]    r_gg, r_gp;
            logic             r_cin, r_amsb, r_bmsb, r_v1;
            logic             w_in_rdy;

            assign w_in_rdy     = !r_v1 | w_ld_out;
            assign bus.In_Ready = w_in_rdy;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_v1   <= 1'b0;
                    r_g    <= '0;
                    r_p    <= '0;
                    r_gg   <= '0;
                    r_gp   <= '0;
                    r_cin  <= 1'b0;
                    r_amsb <= 1'b0;
                    r_bmsb <= 1'b0;
                end else if (w_in_rdy) begin
                    r_v1 <= bus.In_Valid;
                    if (bus.In_Valid) begin
                        r_g    <= w_g;
                        r_p    <= w_p;
                        r_gg   <= w_gg;
                        r_gp   <= w_gp;
                        r_cin  <= w_cin;
                        r_amsb <= bus.A[WIDTH-1];
                        r_bmsb <= w_beff[WIDTH-1];
                    end
                end
            end

            assign w_s_g    = r_g;
            assign w_s_p    = r_p;
            assign w_s_gg   = r_gg;
            assign w_s_gp   = r_gp;
            assign w_s_cin  = r_cin;
            assign w_s_amsb = r_amsb;
            assign w_s_bmsb = r_bmsb;
            assign w_s_vld  = r_v1;
        end else begin : g_one_stage
            assign bus.In_Ready = w_ld_out;
            assign w_s_g    = w_g;
            assign w_s_p    = w_p;
            assign w_s_gg   = w_gg;
            assign w_s_gp   = w_gp;
            assign w_s_cin  = w_cin;
            assign w_s_amsb = bus.A[WIDTH-1];
            assign w_s_bmsb = w_beff[WIDTH-1];
            assign w_s_vld  = bus.In_Valid;
        end
    endgenerate

    // Group carries as flat sum-of-products over GG/GP; ripple only inside a group
    logic [NG:0]      w_cg;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout, w_ovf, w_zero;

    always_comb begin
        logic t_prod, t_acc, t_c;
        w_cg  = '0;
        w_sum = '0;
        for (int j = 0; j <= NG; j++) begin
            t_prod = w_s_cin;
            for (int m = 0; m < j; m++) t_prod = t_prod & w_s_gp[m];
            t_acc = t_prod;
            for (int k = 0; k < j; k++) begin
                t_prod = w_s_gg[k];
                for (int m = k + 1; m < j; m++) t_prod = t_prod & w_s_gp[m];
                t_acc = t_acc | t_prod;
            end
            w_cg[j] = t_acc;
        end
        for (int j = 0; j < NG; j++) begin
            t_c = w_cg[j];
            for (int k = 0; k < GROUP; k++) begin
                w_sum[j*GROUP+k] = w_s_p[j*GROUP+k] ^ t_c;
                t_c = w_s_g[j*GROUP+k] | (w_s_p[j*GROUP+k] & t_c);
            end
        end
    end

    assign w_cout = w_cg[NG];
    assign w_ovf  = (w_s_amsb == w_s_bmsb) & (w_sum[WIDTH-1] != w_s_amsb);
    assign w_zero = (w_sum == '0);

    logic [WIDTH-1:0] r_sum;
    logic             r_cout, r_ovf, r_zero;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ov   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_ld_out) begin
            r_ov <= w_s_vld;
            if (w_s_vld) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= w_zero;
            end
        end
    end

    assign bus.Out_Valid = r_ov;
    assign bus.Sum       = r_sum;
    assign bus.Cout      = r_cout;
    assign bus.Overflow  = r_ovf;
    assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed vectors, backpressure and reset sequences on a 16/4/2 adder,
// then random streaming on it and on a 32/8/1 instance against a reference model.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) b0();
    pipelined_cla_adder_if #(.WIDTH(32)) b1();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .LATENCY(2)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .bus(b0));
    pipelined_cla_adder #(.WIDTH(32), .GROUP(8), .LATENCY(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .bus(b1));

    localparam int NOPS  = 10000;
    localparam int LIMIT = 60000;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic c, input logic o, input logic z,
                                       input logic [31:0] s);
        return {29'b0, c, o, z, s};
    endfunction

    // Reference arithmetic using plain integer addition
    function automatic logic [63:0] ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
        logic [64:0] s;
        logic [63:0] mask, am, bb, sum;
        logic        c, o;
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        bb   = sub ? (~b & mask) : (b & mask);
        s    = {1'b0, am} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
        sum  = s[63:0] & mask;
        c    = s[w];
        o    = (am[w-1] == bb[w-1]) && (sum[w-1] != am[w-1]);
        return pk(c, o, (sum == 64'd0), sum[31:0]);
    endfunction

    function automatic logic [63:0] out0();
        return pk(b0.Cout, b0.Overflow, b0.Zero, {16'd0, b0.Sum});
    endfunction

    function automatic logic [63:0] out1();
        return pk(b1.Cout, b1.Overflow, b1.Zero, b1.Sum);
    endfunction

    typedef struct {
        logic        sub;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    vec_t tv[13];

    task automatic drive0(input logic sub, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
        b0.Sub = sub; b0.A = a; b0.B = b; b0.Cin = cin; b0.In_Valid = 1'b1;
    endtask

    initial begin
        int seen;
        tv[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 16'hA51B, 16'h52BB, 1'b1, 16'hF7D7, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tv[10] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};

        b0.In_Valid = 1'b0; b0.A = '0; b0.B = '0; b0.Cin = 1'b0; b0.Sub = 1'b0; b0.Out_Ready = 1'b1;
        b1.In_Valid = 1'b0; b1.A = '0; b1.B = '0; b1.Cin = 1'b0; b1.Sub = 1'b0; b1.Out_Ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, b0.Out_Valid}, 64'd0);
        check("rst_outputs", out0(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, b0.In_Ready}, 64'd1);

        // Directed vectors, one at a time, two-edge latency
        for (int i = 0; i < 13; i++) begin
            drive0(tv[i].sub, tv[i].a, tv[i].b, tv[i].cin);
            @(negedge clk);
            b0.In_Valid = 1'b0;
            check($sformatf("lat_early_%0d", i), {63'd0, b0.Out_Valid}, 64'd0);
            @(negedge clk);
            check($sformatf("vec_valid_%0d", i), {63'd0, b0.Out_Valid}, 64'd1);
            check($sformatf("vec_%0d", i), out0(),
                  pk(tv[i].cout, tv[i].ovf, tv[i].zero, {16'd0, tv[i].sum}));
        end
        @(negedge clk);

        // Backpressure: 3 offered with Out_Ready=0, only 2 fit
        b0.Out_Ready = 1'b0;
        drive0(1'b0, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        drive0(1'b0, 16'h0003, 16'h0004, 1'b0);
        @(negedge clk);
        drive0(1'b1, 16'h0010, 16'h0001, 1'b0);
        #1;
        check("bp_in_ready_full", {63'd0, b0.In_Ready}, 64'd0);
        check("bp_first_out", {31'd0, b0.Out_Valid, out0()[31:0]}, {31'd0, 1'b1, 32'h0002});
        @(negedge clk);
        check("bp_still_full", {63'd0, b0.In_Ready}, 64'd0);
        check("bp_hold", out0(), pk(1'b0, 1'b0, 1'b0, 32'h0002));
        b0.Out_Ready = 1'b1;
        #1;
        check("bp_ready_through", {63'd0, b0.In_Ready}, 64'd1);
        @(negedge clk);
        b0.In_Valid = 1'b0;
        check("bp_second", {31'd0, b0.Out_Valid, out0()[31:0]}, {31'd0, 1'b1, 32'h0007});
        @(negedge clk);
        check("bp_third", out0(), pk(1'b1, 1'b0, 1'b0, 32'h000F));
        check("bp_third_valid", {63'd0, b0.Out_Valid}, 64'd1);
        @(negedge clk);
        check("bp_empty", {63'd0, b0.Out_Valid}, 64'd0);

        // Asynchronous reset with two operations in flight
        b0.Out_Ready = 1'b0;
        drive0(1'b0, 16'h0100, 16'h0001, 1'b0);
        @(negedge clk);
        drive0(1'b0, 16'h0200, 16'h0002, 1'b0);
        @(negedge clk);
        b0.In_Valid = 1'b0;
        check("pre_rst_valid", {63'd0, b0.Out_Valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, b0.Out_Valid}, 64'd0);
        check("async_rst_outputs", out0(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b0.Out_Ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (b0.Out_Valid) seen++;
        end
        check("no_stale", 64'(seen), 64'd0);
        check("post_rst_ready", {63'd0, b0.In_Ready}, 64'd1);
        drive0(1'b0, 16'h0002, 16'h0003, 1'b0);
        @(negedge clk);
        b0.In_Valid = 1'b0;
        check("post_rst_lat", {63'd0, b0.Out_Valid}, 64'd0);
        @(negedge clk);
        check("post_rst_op", {31'd0, b0.Out_Valid, out0()[31:0]}, {31'd0, 1'b1, 32'h0005});
        @(negedge clk);

        // Random streaming on both instances
        fork
            begin : s0
                logic [63:0] q0[$];
                logic [63:0] prev;
                logic        held;
                int          acc, got, cyc;
                acc = 0; got = 0; cyc = 0; held = 1'b0; prev = '0;
                while ((acc < NOPS || q0.size() > 0) && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    if (held) check("hold0", out0(), prev);
                    b0.In_Valid  = (acc < NOPS) && ($urandom_range(0, 1) == 1);
                    b0.A         = 16'($urandom);
                    b0.B         = 16'($urandom);
                    b0.Cin       = 1'($urandom);
                    b0.Sub       = 1'($urandom);
                    b0.Out_Ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (b0.In_Valid && b0.In_Ready) begin
                        q0.push_back(ref_op(16, {48'd0, b0.A}, {48'd0, b0.B}, b0.Cin, b0.Sub));
                        acc++;
                    end
                    if (b0.Out_Valid && b0.Out_Ready) begin
                        if (q0.size() == 0) check("spurious0", 64'd1, 64'd0);
                        else check("stream0", out0(), q0.pop_front());
                        got++;
                    end
                    held = b0.Out_Valid && !b0.Out_Ready;
                    prev = out0();
                end
                b0.In_Valid = 1'b0;
                check("count0", 64'(got), 64'(NOPS));
                check("timeout0", 64'(cyc < LIMIT), 64'd1);
            end
            begin : s1
                logic [63:0] q1[$];
                logic [63:0] prev;
                logic        held;
                int          acc, got, cyc;
                acc = 0; got = 0; cyc = 0; held = 1'b0; prev = '0;
                while ((acc < NOPS || q1.size() > 0) && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    if (held) check("hold1", out1(), prev);
                    b1.In_Valid  = (acc < NOPS) && ($urandom_range(0, 1) == 1);
                    b1.A         = $urandom;
                    b1.B         = $urandom;
                    b1.Cin       = 1'($urandom);
                    b1.Sub       = 1'($urandom);
                    b1.Out_Ready = ($urandom_range(0, 3) != 0);
                    #1;
                    if (b1.In_Valid && b1.In_Ready) begin
                        q1.push_back(ref_op(32, {32'd0, b1.A}, {32'd0, b1.B}, b1.Cin, b1.Sub));
                        acc++;
                    end
                    if (b1.Out_Valid && b1.Out_Ready) begin
                        if (q1.size() == 0) check("spurious1", 64'd1, 64'd0);
                        else check("stream1", out1(), q1.pop_front());
                        got++;
                    end
                    held = b1.Out_Valid && !b1.Out_Ready;
                    prev = out1();
                end
                b1.In_Valid = 1'b0;
                check("count1", 64'(got), 64'(NOPS));
                check("timeout1", 64'(cyc < LIMIT), 64'd1);
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
